// File: rtl/hc08_selftest_seq_if.sv
// Host handshake and HC08 pin bundle for the HC08 self-test sequencer.
// The master side is the host plus the chip under test; the slave side is the sequencer.
interface hc08_selftest_seq_if;
  logic       START;
  logic       ABORT;
  logic [4:1] A_DRV;
  logic [4:1] B_DRV;
  logic [4:1] Y_IN;
  logic       BUSY;
  logic       DONE;
  logic       PASS;
  logic [4:1] FAIL_MAP;
  logic [7:0] FAIL_VEC;
  logic       FAIL_SEEN;
  logic [7:0] VEC_IDX;

  modport master (
    output START, ABORT, Y_IN,
    input  A_DRV, B_DRV, BUSY, DONE, PASS, FAIL_MAP, FAIL_VEC, FAIL_SEEN, VEC_IDX
  );

  modport slave (
    input  START, ABORT, Y_IN,
    output A_DRV, B_DRV, BUSY, DONE, PASS, FAIL_MAP, FAIL_VEC, FAIL_SEEN, VEC_IDX
  );
endinterface

// File: rtl/hc08_selftest_seq.sv
// Exhaustive 256-vector self-test of a quad 2-input AND block (on-chip or external 74HC08),
// with a sticky per-gate fail map, first-failure capture and a START/BUSY/DONE handshake.
module hc08_selftest_seq #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input logic                CLK,
  input logic                RST_N,
  hc08_selftest_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, FINISH} state_t;

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [7:0]       vec, vec_nxt;
  logic [4:1]       y_s1, y_s;
  logic [4:1]       fail_map, fail_map_nxt;
  logic [7:0]       fail_vec, fail_vec_nxt;
  logic             fail_seen, fail_seen_nxt;
  logic             pass_q, pass_nxt;
  logic [4:1]       expect_y, mism;
  logic             busy;

  assign expect_y = vec[7:4] & vec[3:0];
  assign mism     = y_s ^ expect_y;

  // NOTE: every signal gets its hold value first so no path through the case leaves one unassigned (no latches).
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    vec_nxt       = vec;
    fail_map_nxt  = fail_map;
    fail_vec_nxt  = fail_vec;
    fail_seen_nxt = fail_seen;
    pass_nxt      = pass_q;

    unique case (state)
      IDLE: begin
        if (bus.START && !bus.ABORT) begin
          state_nxt     = SETTLE;
          vec_nxt       = '0;
          cnt_nxt       = RELOAD;
          fail_map_nxt  = '0;
          fail_vec_nxt  = '0;
          fail_seen_nxt = 1'b0;
          pass_nxt      = 1'b0;
        end
      end
      SETTLE: begin
        if (bus.ABORT) begin
          state_nxt = IDLE;
          vec_nxt   = '0;
        end else if (cnt == '0) begin
          state_nxt = SAMPLE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      SAMPLE: begin
        // The mismatch is recorded even when this cycle is also aborting.
        fail_map_nxt = fail_map | mism;
        if (mism != '0 && !fail_seen) begin
          fail_vec_nxt  = vec;
          fail_seen_nxt = 1'b1;
        end
        if (bus.ABORT) begin
          state_nxt = IDLE;
          vec_nxt   = '0;
        end else if (vec == 8'hFF) begin
          state_nxt = FINISH;
        end else begin
          state_nxt = SETTLE;
          vec_nxt   = vec + 8'd1;
          cnt_nxt   = RELOAD;
        end
      end
      FINISH: begin
        state_nxt = IDLE;
        vec_nxt   = '0;
        pass_nxt  = (fail_map == '0);
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= IDLE;
      cnt       <= '0;
      vec       <= '0;
      y_s1      <= '0;
      y_s       <= '0;
      fail_map  <= '0;
      fail_vec  <= '0;
      fail_seen <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      vec       <= vec_nxt;
      y_s1      <= bus.Y_IN;
      y_s       <= y_s1;
      fail_map  <= fail_map_nxt;
      fail_vec  <= fail_vec_nxt;
      fail_seen <= fail_seen_nxt;
      pass_q    <= pass_nxt;
    end
  end

  assign busy          = (state == SETTLE) || (state == SAMPLE);
  assign bus.BUSY      = busy;
  assign bus.DONE      = (state == FINISH);
  // PASS is already valid in the DONE cycle, then held until the next accepted START.
  assign bus.PASS      = (state == FINISH) ? (fail_map == '0) : pass_q;
  assign bus.A_DRV     = busy ? vec[7:4] : 4'b0000;
  assign bus.B_DRV     = busy ? vec[3:0] : 4'b0000;
  assign bus.VEC_IDX   = vec;
  assign bus.FAIL_MAP  = fail_map;
  assign bus.FAIL_VEC  = fail_vec;
  assign bus.FAIL_SEEN = fail_seen;

endmodule
